// File: rtl/sync_pack_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sync_pack_fifo                                                 |
// | Brief   : single-clock packing FIFO, narrow write lanes -> wide words    |
// | Revision: 1.0 - initial parametrised release with flush/valid-lane count |
// +--------------------------------------------------------------------------+
module sync_pack_fifo #(
  parameter int WR_DATA_WIDTH    = 8,
  parameter int RATIO            = 16,
  parameter int DEPTH_WIDTH      = 8,
  parameter int FIRST_LANE_MSB   = 0,
  parameter int ALMOST_FULL_NUM  = 4080,
  parameter int ALMOST_EMPTY_NUM = 4,
  localparam int LW              = $clog2(RATIO),
  localparam int RD_DATA_WIDTH   = WR_DATA_WIDTH * RATIO
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WR_DATA_WIDTH-1:0]     wr_data,
  input  logic                         wr_flush,
  output logic                         wr_full,
  output logic                         almost_full,
  output logic [DEPTH_WIDTH+LW:0]      wr_water_level,
  input  logic                         rd_en,
  output logic [RD_DATA_WIDTH-1:0]     rd_data,
  output logic [LW:0]                  rd_valid_lanes,
  output logic                         rd_valid,
  output logic                         rd_empty,
  output logic                         almost_empty,
  output logic [DEPTH_WIDTH:0]         rd_water_level
);

  localparam int                   DEPTH       = 2 ** DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] c_depth     = (DEPTH_WIDTH + 1)'(DEPTH);
  localparam logic [LW-1:0]        c_last_lane = LW'(RATIO - 1);

  logic [RD_DATA_WIDTH-1:0] r_mem_data  [DEPTH];
  logic [LW:0]              r_mem_lanes [DEPTH];

  logic [DEPTH_WIDTH-1:0]   r_wr_ptr;
  logic [DEPTH_WIDTH-1:0]   r_rd_ptr;
  logic [DEPTH_WIDTH:0]     r_word_cnt;
  logic [LW-1:0]            r_lane_cnt;
  logic [RD_DATA_WIDTH-1:0] r_pack;

  logic                     w_mem_full;
  logic                     w_wr_acc;
  logic                     w_rd_acc;
  logic                     w_commit;
  logic [LW-1:0]            w_slot;
  logic [LW:0]              w_lanes_next;
  logic [RD_DATA_WIDTH-1:0] w_pack_next;

  assign w_mem_full     = (r_word_cnt == c_depth);
  assign wr_full        = w_mem_full & (r_lane_cnt == c_last_lane);
  assign rd_empty       = (r_word_cnt == '0);
  assign w_wr_acc       = wr_en & ~wr_full;
  assign w_rd_acc       = rd_en & ~rd_empty;

  // RATIO is a power of two, so word_cnt*RATIO + lane_cnt is a plain concatenation
  assign wr_water_level = {r_word_cnt, r_lane_cnt};
  assign rd_water_level = r_word_cnt;
  assign almost_full    = (int'(wr_water_level) >= ALMOST_FULL_NUM);
  assign almost_empty   = (int'(r_word_cnt) <= ALMOST_EMPTY_NUM);

  assign w_slot       = (FIRST_LANE_MSB != 0) ? (c_last_lane - r_lane_cnt) : r_lane_cnt;
  assign w_lanes_next = {1'b0, r_lane_cnt} + {{LW{1'b0}}, w_wr_acc};

  // A flush that coincides with a write commits the word including the new lane
  assign w_commit = (w_wr_acc & (r_lane_cnt == c_last_lane))
                  | (wr_flush & ~w_mem_full & (w_lanes_next != '0));

  always_comb begin
    w_pack_next = r_pack;
    for (int i = 0; i < RATIO; i++) begin
      if (w_wr_acc && (w_slot == LW'(i))) begin
        w_pack_next[i*WR_DATA_WIDTH +: WR_DATA_WIDTH] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem_data[r_wr_ptr]  <= w_pack_next;
      r_mem_lanes[r_wr_ptr] <= w_lanes_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_word_cnt     <= '0;
      r_lane_cnt     <= '0;
      r_pack         <= '0;
      rd_data        <= '0;
      rd_valid_lanes <= '0;
      rd_valid       <= 1'b0;
    end else begin
      // Pack register is cleared on commit so unfilled lanes of a flushed word read as zero
      if (w_commit) begin
        r_wr_ptr   <= r_wr_ptr + DEPTH_WIDTH'(1);
        r_pack     <= '0;
        r_lane_cnt <= '0;
      end else begin
        r_pack     <= w_pack_next;
        r_lane_cnt <= w_lanes_next[LW-1:0];
      end

      if (w_rd_acc) begin
        r_rd_ptr       <= r_rd_ptr + DEPTH_WIDTH'(1);
        rd_data        <= r_mem_data[r_rd_ptr];
        rd_valid_lanes <= r_mem_lanes[r_rd_ptr];
      end
      rd_valid <= w_rd_acc;

      case ({w_commit, w_rd_acc})
        2'b10:   r_word_cnt <= r_word_cnt + (DEPTH_WIDTH + 1)'(1);
        2'b01:   r_word_cnt <= r_word_cnt - (DEPTH_WIDTH + 1)'(1);
        default: r_word_cnt <= r_word_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_pack_fifo.sv
`default_nettype none
// Testbench for sync_pack_fifo: randomized traffic against a queue-based model.
module tb_sync_pack_fifo;

  localparam int W     = 8;
  localparam int R     = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int RDW   = W * R;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           wr_en = 1'b0;
  logic           wr_flush = 1'b0;
  logic           rd_en = 1'b0;
  logic [W-1:0]   wr_data = '0;
  logic           wr_full, almost_full, rd_valid, rd_empty, almost_empty;
  logic [DW+4:0]  wr_water_level;
  logic [RDW-1:0] rd_data;
  logic [4:0]     rd_valid_lanes;
  logic [DW:0]    rd_water_level;

  sync_pack_fifo #(
    .WR_DATA_WIDTH(W), .RATIO(R), .DEPTH_WIDTH(DW), .FIRST_LANE_MSB(0),
    .ALMOST_FULL_NUM(4080), .ALMOST_EMPTY_NUM(4)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_data(wr_data), .wr_flush(wr_flush),
    .wr_full(wr_full), .almost_full(almost_full), .wr_water_level(wr_water_level),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid_lanes(rd_valid_lanes),
    .rd_valid(rd_valid), .rd_empty(rd_empty), .almost_empty(almost_empty),
    .rd_water_level(rd_water_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RDW-1:0] d;
    int             n;
  } word_t;

  word_t          m_words[$];
  logic [W-1:0]   m_pend[$];
  logic [RDW-1:0] exp_data  = '0;
  int             exp_lanes = 0;
  bit             exp_valid = 1'b0;
  int             m_commits = 0;
  int             errors = 0;
  int             checks = 0;

  function automatic logic [RDW-1:0] pack_pending();
    logic [RDW-1:0] v;
    v = '0;
    foreach (m_pend[i]) v[i*W +: W] = m_pend[i];
    return v;
  endfunction

  function automatic int m_level();
    return m_words.size() * R + m_pend.size();
  endfunction

  task automatic model_reset();
    m_words.delete();
    m_pend.delete();
    exp_data  = '0;
    exp_lanes = 0;
    exp_valid = 1'b0;
  endtask

  // Drive one cycle and advance the model; returns #1 after the edge.
  task automatic step(input bit we, input logic [W-1:0] wd, input bit fl, input bit re);
    int    wc, lc;
    bit    acc, racc;
    word_t w;
    wc   = m_words.size();
    lc   = m_pend.size();
    acc  = we && !(wc == DEPTH && lc == R - 1);
    racc = re && (wc > 0);
    wr_en = we; wr_data = wd; wr_flush = fl; rd_en = re;
    @(posedge clk);
    if (racc) begin
      w = m_words.pop_front();
      exp_data = w.d; exp_lanes = w.n; exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    if (acc) m_pend.push_back(wd);
    if (m_pend.size() == R || (fl && m_pend.size() > 0 && wc < DEPTH)) begin
      w.d = pack_pending();
      w.n = m_pend.size();
      m_words.push_back(w);
      m_pend.delete();
      m_commits++;
    end
    #1;
    wr_en = 1'b0; wr_flush = 1'b0; rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2 && m_words.size() > 0; k++) step(0, '0, 0, 1);
    if (m_pend.size() > 0) step(0, '0, 1, 0);
    for (int k = 0; k < 3 && m_words.size() > 0; k++) step(0, '0, 0, 1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL reset_rd_empty got=%b want=1", rd_empty); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got=%b want=1", almost_empty); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL reset_wr_full got=%b want=0", wr_full); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got=%b want=0", almost_full); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
    checks++; if (rd_valid_lanes !== 5'd0) begin errors++; $display("FAIL reset_lanes got=%0d want=0", rd_valid_lanes); end
    checks++; if (wr_water_level !== '0) begin errors++; $display("FAIL reset_wr_level got=%0d want=0", wr_water_level); end
    #2 rst = 1'b1;
    model_reset();
    step(0, '0, 0, 0);
  endtask

  task automatic test_full_word();
    for (int i = 0; i < R; i++) begin
      step(1, W'(i), 0, 0);
      if (i == R - 2) begin
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL word_empty_before got=%b want=1", rd_empty); end
      end
    end
    checks++; if (rd_empty !== 1'b0) begin errors++; $display("FAIL word_empty_after got=%b want=0", rd_empty); end
    step(0, '0, 0, 1);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL word_rd_valid got=%b want=1", rd_valid); end
    checks++; if (rd_data !== 128'h0F0E0D0C0B0A09080706050403020100) begin errors++; $display("FAIL word_rd_data got=%h want=0f0e..0100", rd_data); end
    checks++; if (rd_valid_lanes !== 5'd16) begin errors++; $display("FAIL word_lanes got=%0d want=16", rd_valid_lanes); end
    step(0, '0, 0, 0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL word_valid_pulse got=%b want=0", rd_valid); end
    checks++; if (rd_data !== 128'h0F0E0D0C0B0A09080706050403020100) begin errors++; $display("FAIL word_data_hold got=%h", rd_data); end
  endtask

  task automatic test_flush();
    step(1, 8'hA1, 0, 0);
    step(1, 8'hA2, 0, 0);
    step(1, 8'hA3, 0, 0);
    checks++; if (wr_water_level !== 13'd3) begin errors++; $display("FAIL flush_level_before got=%0d want=3", wr_water_level); end
    step(0, '0, 1, 0);
    checks++; if (wr_water_level !== 13'd16) begin errors++; $display("FAIL flush_level_after got=%0d want=16", wr_water_level); end
    step(0, '0, 1, 0);
    checks++; if (rd_water_level !== 9'd1) begin errors++; $display("FAIL flush_noop got=%0d want=1", rd_water_level); end
    step(0, '0, 0, 1);
    checks++; if (rd_data !== 128'h00A3A2A1) begin errors++; $display("FAIL flush_rd_data got=%h want=00a3a2a1", rd_data); end
    checks++; if (rd_valid_lanes !== 5'd3) begin errors++; $display("FAIL flush_lanes got=%0d want=3", rd_valid_lanes); end
  endtask

  task automatic test_fill_full();
    for (int n = 0; n < DEPTH * R + R - 1; n++) begin
      step(1, W'($urandom), 0, 0);
      checks++; if (almost_full !== (m_level() >= 4080)) begin errors++; $display("FAIL fill_almost_full lvl=%0d got=%b", m_level(), almost_full); end
    end
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL full_wr_full got=%b want=1", wr_full); end
    checks++; if (wr_water_level !== 13'd4111) begin errors++; $display("FAIL full_level got=%0d want=4111", wr_water_level); end
    step(1, 8'hEE, 0, 0);
    checks++; if (wr_water_level !== 13'd4111) begin errors++; $display("FAIL full_refused got=%0d want=4111", wr_water_level); end
    step(0, '0, 1, 0);
    checks++; if (rd_water_level !== 9'd256) begin errors++; $display("FAIL full_flush_ignored got=%0d want=256", rd_water_level); end
    step(1, 8'h5A, 0, 1);
    checks++; if (wr_water_level !== 13'd4095) begin errors++; $display("FAIL full_rd_wr got=%0d want=4095", wr_water_level); end
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp_data) begin errors++; $display("FAIL full_rd_data got=%h want=%h", rd_data, exp_data); end
    step(1, 8'h5A, 0, 0);
    checks++; if (rd_water_level !== 9'd256) begin errors++; $display("FAIL full_retry got=%0d want=256", rd_water_level); end
    for (int k = 0; k < DEPTH + 2 && m_words.size() > 0; k++) begin
      step(0, '0, 0, 1);
      checks++; if (rd_data !== exp_data || rd_valid_lanes !== 5'(exp_lanes)) begin errors++; $display("FAIL full_drain k=%0d got=%h want=%h", k, rd_data, exp_data); end
    end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL full_drained got=%b want=1", rd_empty); end
  endtask

  task automatic test_simultaneous();
    for (int n = 0; n < 5 * R + R - 1; n++) step(1, W'($urandom), 0, 0);
    checks++; if (rd_water_level !== 9'd5 || almost_empty !== 1'b0) begin errors++; $display("FAIL simul_pre lvl=%0d ae=%b want 5/0", rd_water_level, almost_empty); end
    step(1, W'($urandom), 0, 1);
    checks++; if (rd_water_level !== 9'd5) begin errors++; $display("FAIL simul_level got=%0d want=5", rd_water_level); end
    checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL simul_ae got=%b want=0", almost_empty); end
    step(0, '0, 0, 1);
    checks++; if (rd_water_level !== 9'd4 || almost_empty !== 1'b1) begin errors++; $display("FAIL simul_ae4 lvl=%0d ae=%b want 4/1", rd_water_level, almost_empty); end
    drain();
  endtask

  task automatic test_empty_read();
    step(0, '0, 0, 1);
    checks++; if (rd_valid !== 1'b0 || rd_data !== exp_data) begin errors++; $display("FAIL empty_read valid=%b data=%h want 0/%h", rd_valid, rd_data, exp_data); end
    for (int n = 0; n < R - 1; n++) step(1, W'($urandom), 0, 0);
    step(1, W'($urandom), 0, 1);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL fallthrough_valid got=%b want=0", rd_valid); end
    checks++; if (rd_data !== exp_data) begin errors++; $display("FAIL fallthrough_data got=%h want=%h", rd_data, exp_data); end
    checks++; if (rd_water_level !== 9'd1) begin errors++; $display("FAIL fallthrough_level got=%0d want=1", rd_water_level); end
    drain();
  endtask

  task automatic test_stream();
    int target;
    bit we, re, fl;
    target = m_commits + 1000;
    for (int cyc = 0; cyc < 40000 && m_commits < target; cyc++) begin
      we = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 31) == 0);
      re = ((cyc / 1500) % 2 == 1) ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 1) == 0);
      step(we, W'($urandom), fl, re);
      checks++; if (rd_valid !== exp_valid) begin errors++; $display("FAIL stream_valid cyc=%0d got=%b want=%b", cyc, rd_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (rd_data !== exp_data || rd_valid_lanes !== 5'(exp_lanes)) begin errors++; $display("FAIL stream_data cyc=%0d got=%h/%0d want=%h/%0d", cyc, rd_data, rd_valid_lanes, exp_data, exp_lanes); end
      end
      checks++; if (wr_water_level !== 13'(m_level()) || rd_empty !== (m_words.size() == 0)) begin errors++; $display("FAIL stream_level cyc=%0d got=%0d want=%0d", cyc, wr_water_level, m_level()); end
    end
    checks++; if (m_commits < target) begin errors++; $display("FAIL stream_timeout commits=%0d want=%0d", m_commits, target); end
    drain();
  endtask

  task automatic test_async_reset();
    for (int n = 0; n < 4 * R + 7; n++) step(1, W'($urandom), 0, 0);
    step(0, '0, 0, 1);
    #1 rst = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || rd_data !== '0 || rd_valid_lanes !== 5'd0) begin errors++; $display("FAIL async_rd got v=%b d=%h l=%0d want 0", rd_valid, rd_data, rd_valid_lanes); end
    checks++; if (rd_empty !== 1'b1 || almost_empty !== 1'b1 || wr_full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL async_flags got e=%b ae=%b f=%b af=%b", rd_empty, almost_empty, wr_full, almost_full); end
    checks++; if (wr_water_level !== '0 || rd_water_level !== '0) begin errors++; $display("FAIL async_levels got=%0d/%0d want=0", wr_water_level, rd_water_level); end
    model_reset();
    #1 rst = 1'b1;
    step(0, '0, 0, 1);
    checks++; if (rd_valid !== 1'b0 || rd_empty !== 1'b1) begin errors++; $display("FAIL post_reset valid=%b empty=%b want 0/1", rd_valid, rd_empty); end
    for (int n = 0; n < R; n++) step(1, W'($urandom), 0, 0);
    step(0, '0, 0, 1);
    checks++; if (rd_data !== exp_data || rd_valid_lanes !== 5'd16) begin errors++; $display("FAIL post_reset_data got=%h want=%h", rd_data, exp_data); end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL post_reset_old got=%b want=1", rd_empty); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush();
    test_fill_full();
    test_simultaneous();
    test_empty_read();
    test_stream();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_pack_fifo.md
Name: sync_pack_fifo

Overview:
Parametrised single-clock packing FIFO, successor to the fixed 8-to-128 receive FIFO. It accumulates narrow write lanes into wide read words. Ratio, lane ordering and thresholds are set by parameters. It adds partial-word flush with a per-word valid-lane count, plus exact water levels on both sides. It sits between byte-serial peripherals (UART/SPI receive paths) and the wide AHB-side consumers of the Cortex-M1 subsystem.

Parameters:
WR_DATA_WIDTH, 8, write lane width in bits (1..64)
RATIO, 16, lanes per read word (power of two, 2..64); RD_DATA_WIDTH = WR_DATA_WIDTH*RATIO
DEPTH_WIDTH, 8, log2 of read-word storage depth; DEPTH = 2**DEPTH_WIDTH
FIRST_LANE_MSB, 0, 0: first written lane lands in bits [WR_DATA_WIDTH-1:0]; 1: in the top lane
ALMOST_FULL_NUM, 4080, almost_full threshold in lanes
ALMOST_EMPTY_NUM, 4, almost_empty threshold in words

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous reset, active-low (asserted at 0)
wr_en  in  1  write one lane
wr_data  in  WR_DATA_WIDTH  lane data
wr_flush  in  1  commit the partially filled word, zero-padded
wr_full  out  1  a write will not be accepted
almost_full  out  1  wr_water_level >= ALMOST_FULL_NUM
wr_water_level  out  DEPTH_WIDTH+LW+1  stored lanes = word_cnt*RATIO + lane_cnt, where LW = log2(RATIO)
rd_en  in  1  pop one word
rd_data  out  RD_DATA_WIDTH  popped word
rd_valid_lanes  out  LW+1  number of valid lanes in rd_data (1..RATIO)
rd_valid  out  1  rd_data/rd_valid_lanes updated this cycle
rd_empty  out  1  no committed word
almost_empty  out  1  word_cnt <= ALMOST_EMPTY_NUM
rd_water_level  out  DEPTH_WIDTH+1  committed words (word_cnt)

Behaviour:
- Reset (rst=0, asynchronous) clears: pointers, word_cnt, lane_cnt, pack register, rd_data=0, rd_valid_lanes=0, rd_valid=0. Resulting outputs: rd_empty=1, almost_empty=1, wr_full=0, almost_full=0 (for thresholds >0). A reset mid-word discards the partial word. Release takes effect on the first clk edge after rst rises.
- Storage: DEPTH words of RD_DATA_WIDTH plus LW+1 lane-count bits each. Pointers wrap modulo DEPTH. word_cnt ranges 0..DEPTH.
- Write accept: wr_acc = wr_en & ~wr_full.
  - The lane is stored into pack-register slot lane_cnt (mirrored if FIRST_LANE_MSB), and lane_cnt increments.
  - On the RATIO-th lane, the packed word plus the lane count RATIO is committed to memory in the same edge, and lane_cnt returns to 0.
- wr_full = (word_cnt==DEPTH) & (lane_cnt==RATIO-1). The pack register may fill while memory is full, but the commit lane is refused. A simultaneous rd_en does not lift wr_full in that cycle.
- wr_flush: when lane_cnt>0 and word_cnt<DEPTH, it commits the pack register with unfilled lanes zero, records lane count = lane_cnt, and clears lane_cnt.
  - With lane_cnt==0, flush is a no-op.
  - With word_cnt==DEPTH, flush is ignored and the data is retained.
  - wr_en together with wr_flush: the lane is packed first, then the combined word is committed (count = lane_cnt+1). This is a single commit.
- Read accept: rd_acc = rd_en & ~rd_empty. Ignored reads change nothing.
  - One-cycle latency: the edge after rd_acc loads rd_data/rd_valid_lanes, and rd_valid pulses high for one cycle.
  - rd_data holds its value between reads.
- Simultaneous commit and read: word_cnt stays unchanged. A read from an empty FIFO while a commit occurs in the same cycle is refused, so there is no fall-through.
- Flags and levels are derived combinationally from the registered word_cnt/lane_cnt and are all valid in the cycle after the causing edge.
- rd_empty = (word_cnt==0). A partial word in the pack register does not clear rd_empty.

Test Plan:
- Reset, then write 0x00..0x0F (RATIO=16) → rd_empty falls after the 16th lane. rd_en → next cycle rd_data=0x0F0E..0100, rd_valid_lanes=16, rd_valid=1 for one cycle.
- Write 3 lanes 0xA1,0xA2,0xA3, then wr_flush → wr_water_level reads 3 before the flush and 16 after it. The read returns 0x…00A3A2A1 (upper lanes zero) with rd_valid_lanes=3.
- Fill 256 words plus 15 lanes → wr_full=1, almost_full=1, wr_water_level=4111. A 16th lane write is refused. After one read, the retried write is accepted and word_cnt returns to 256.
- With word_cnt=5 and a commit coinciding with rd_acc → rd_water_level stays 5 and almost_empty stays 0. Reading down to 4 words → almost_empty=1.
- rd_en while empty (including same-cycle commit) → no rd_valid and rd_data unchanged. Pointer wrap: stream 1000 words with random rd_en/wr_en → data order preserved against a scoreboard.
- Assert rst=0 mid-word (7 lanes pending, 3 words stored) → all outputs return to reset values asynchronously. After release the FIFO is empty and the old data never appears.
